// File: rtl/rcon_seq.sv
// AES round-constant sequencer: generates Rcon bytes with a GF(2^8) xtime /
// inverse-xtime datapath and streams them over a valid/ready handshake.
module rcon_seq #(
    parameter int         WORD_W = 32,
    parameter logic [7:0] POLY   = 8'h1b,
    parameter int         IDX_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              dir,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [WORD_W-1:0] dout,
    output logic [IDX_W-1:0]  idx,
    output logic              last,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [1:0] MODE_RSVD = 2'b11;

    state_t           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic             dir_q, dir_d;
    logic [7:0]       byte_q, byte_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [IDX_W-1:0] last_fwd_idx;

    function automatic logic [IDX_W-1:0] seq_len(input logic [1:0] m);
        case (m)
            2'b01:   seq_len = IDX_W'(8);
            2'b10:   seq_len = IDX_W'(7);
            default: seq_len = IDX_W'(10);
        endcase
    endfunction

    // Reverse order starts from the last constant each key size consumes.
    function automatic logic [7:0] final_byte(input logic [1:0] m);
        case (m)
            2'b01:   final_byte = 8'h80;
            2'b10:   final_byte = 8'h40;
            default: final_byte = 8'h36;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? POLY : 8'h00);
    endfunction

    // Undo xtime: an odd byte must have had the reduction applied, so the top bit was set.
    function automatic logic [7:0] inv_xtime(input logic [7:0] b);
        inv_xtime = b[0] ? (((b ^ POLY) >> 1) | 8'h80) : (b >> 1);
    endfunction

    assign last_fwd_idx = seq_len(mode_q) - IDX_W'(1);

    // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        dir_d   = dir_q;
        byte_d  = byte_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        last_d  = last_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        if (start) begin
            if (mode == MODE_RSVD) begin
                state_d = IDLE;
                byte_d  = 8'h00;
                idx_d   = '0;
                valid_d = 1'b0;
                last_d  = 1'b0;
                busy_d  = 1'b0;
                err_d   = 1'b1;
            end else begin
                state_d = RUN;
                mode_d  = mode;
                dir_d   = dir;
                valid_d = 1'b1;
                busy_d  = 1'b1;
                last_d  = 1'b0;
                if (dir) begin
                    byte_d = final_byte(mode);
                    idx_d  = seq_len(mode) - IDX_W'(1);
                end else begin
                    byte_d = 8'h01;
                    idx_d  = '0;
                end
            end
        end else if (state_q == RUN && valid_q && out_ready) begin
            if (last_q) begin
                state_d = IDLE;
                byte_d  = 8'h00;
                idx_d   = '0;
                valid_d = 1'b0;
                last_d  = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end else if (dir_q) begin
                byte_d = inv_xtime(byte_q);
                idx_d  = idx_q - IDX_W'(1);
                last_d = (idx_q == IDX_W'(1));
            end else begin
                byte_d = xtime(byte_q);
                idx_d  = idx_q + IDX_W'(1);
                last_d = (idx_q + IDX_W'(1) == last_fwd_idx);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= 2'b00;
            dir_q   <= 1'b0;
            byte_q  <= 8'h00;
            idx_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            dir_q   <= dir_d;
            byte_q  <= byte_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    generate
        if (WORD_W == 8) begin : g_narrow
            assign dout = byte_q;
        end else begin : g_wide
            assign dout = {byte_q, {(WORD_W-8){1'b0}}};
        end
    endgenerate

    assign out_valid = valid_q;
    assign idx       = idx_q;
    assign last      = last_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_rcon_seq.sv
// Directed bench for rcon_seq: scoreboard of expected words, checked against
// a 32-bit and a 64-bit instance driven by the same stimulus.
module tb_rcon_seq;

    typedef struct {
        logic [7:0] b;
        logic [3:0] i;
        logic       l;
    } word_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic        dir = 1'b0;
    logic        out_ready = 1'b0;

    logic        v32, l32, b32, d32, e32;
    logic [31:0] dout32;
    logic [3:0]  idx32;
    logic        v64, l64, b64, d64, e64;
    logic [63:0] dout64;
    logic [3:0]  idx64;

    int checks = 0;
    int errors = 0;
    word_t sb[$];
    logic [7:0] rc_tab [10];

    rcon_seq #(.WORD_W(32)) dut32 (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .dir(dir),
        .out_ready(out_ready), .out_valid(v32), .dout(dout32), .idx(idx32),
        .last(l32), .busy(b32), .done(d32), .err(e32)
    );

    rcon_seq #(.WORD_W(64)) dut64 (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .dir(dir),
        .out_ready(out_ready), .out_valid(v64), .dout(dout64), .idx(idx64),
        .last(l64), .busy(b64), .done(d64), .err(e64)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag, input logic exp_done);
        check({tag, " valid"}, {63'd0, v32}, 64'd0);
        check({tag, " dout32"}, {32'd0, dout32}, 64'd0);
        check({tag, " dout64"}, dout64, 64'd0);
        check({tag, " idx"}, {60'd0, idx32}, 64'd0);
        check({tag, " last"}, {63'd0, l32}, 64'd0);
        check({tag, " busy"}, {63'd0, b32}, 64'd0);
        check({tag, " done"}, {63'd0, d32}, {63'd0, exp_done});
        check({tag, " err"}, {63'd0, e32}, 64'd0);
    endtask

    function automatic int len_of(input logic [1:0] m);
        return (m == 2'b00) ? 10 : (m == 2'b01) ? 8 : 7;
    endfunction

    task automatic push_seq(input logic [1:0] m, input logic d);
        int n = len_of(m);
        for (int k = 0; k < n; k++) begin
            word_t w;
            w.i = d ? 4'(n - 1 - k) : 4'(k);
            w.b = rc_tab[w.i];
            w.l = (k == n - 1);
            sb.push_back(w);
        end
    endtask

    // Called at a negedge; leaves the first word visible at the next negedge.
    task automatic begin_seq(input logic [1:0] m, input logic d);
        push_seq(m, d);
        start = 1'b1; mode = m; dir = d; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Consumes scoreboard words using a repeating ready pattern. If stop_idx
    // is non-negative, returns (without handshaking) when that word is shown.
    task automatic drain(input logic [15:0] pat, input int plen, input int stop_idx,
                         output int busy_cnt);
        int k = 0;
        int cyc = 0;
        bit fin = 0;
        word_t w;
        busy_cnt = 0;
        while (!fin) begin
            if (cyc > 200 || sb.size() == 0) begin
                checks++; errors++;
                $error("FAIL drain: stalled after %0d cycles, %0d words left", cyc, sb.size());
                out_ready = 1'b0;
                return;
            end
            w = sb[0];
            if (b32) busy_cnt++;
            check("valid", {63'd0, v32}, 64'd1);
            check("dout32", {32'd0, dout32}, {32'd0, w.b, 24'd0});
            check("dout64", dout64, {w.b, 56'd0});
            check("idx", {60'd0, idx32}, {60'd0, w.i});
            check("last", {63'd0, l32}, {63'd0, w.l});
            check("busy", {63'd0, b32}, 64'd1);
            check("done_low", {63'd0, d32}, 64'd0);
            if (stop_idx >= 0 && int'(w.i) == stop_idx) return;
            out_ready = pat[k % plen];
            k++;
            if (out_ready) begin
                void'(sb.pop_front());
                if (w.l) fin = 1;
            end
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        check_idle("after_last", 1'b1);
        @(negedge clk);
        check("done_pulse_end", {63'd0, d32}, 64'd0);
    endtask

    initial begin
        int bc;
        rc_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

        repeat (2) @(negedge clk);
        check_idle("reset", 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // AES-128 forward, ready held high; busy for exactly 10 sampled cycles.
        begin_seq(2'b00, 1'b0);
        drain(16'h0001, 1, -1, bc);
        check("busy_cycles_128", 64'(bc), 64'd10);

        // AES-192 reverse.
        begin_seq(2'b01, 1'b1);
        drain(16'h0001, 1, -1, bc);

        // AES-256 forward with ready pattern 1,0,0,1,0,1.
        begin_seq(2'b10, 1'b0);
        drain(16'b101001, 6, -1, bc);

        // AES-128 reverse, ready alternating.
        begin_seq(2'b00, 1'b1);
        drain(16'b01, 2, -1, bc);

        // Restart at idx 4 into AES-256 reverse; start beats the simultaneous handshake.
        begin_seq(2'b00, 1'b0);
        drain(16'h0001, 1, 4, bc);
        start = 1'b1; mode = 2'b10; dir = 1'b1; out_ready = 1'b1;
        sb.delete();
        push_seq(2'b10, 1'b1);
        @(negedge clk);
        start = 1'b0;
        drain(16'h0001, 1, -1, bc);

        // Reserved mode in IDLE.
        start = 1'b1; mode = 2'b11; dir = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("err_pulse", {63'd0, e32}, 64'd1);
        check("err_valid", {63'd0, v32}, 64'd0);
        check("err_done", {63'd0, d32}, 64'd0);
        check("err_busy", {63'd0, b32}, 64'd0);
        @(negedge clk);
        check("err_end", {63'd0, e32}, 64'd0);

        // Reset at idx 3 with a competing start; then a clean restart.
        begin_seq(2'b00, 1'b0);
        drain(16'h0001, 1, 3, bc);
        rst = 1'b1; start = 1'b1; mode = 2'b01; dir = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check_idle("mid_reset", 1'b0);
        sb.delete();
        @(negedge clk);
        begin_seq(2'b00, 1'b0);
        drain(16'h0001, 1, -1, bc);

        // Start in the done cycle is accepted.
        begin_seq(2'b10, 1'b0);
        drain(16'h0001, 1, 6, bc);
        out_ready = 1'b1;
        @(negedge clk);
        check("done_cycle", {63'd0, d32}, 64'd1);
        push_seq(2'b01, 1'b0);
        void'(sb.pop_front());
        start = 1'b1; mode = 2'b01; dir = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        drain(16'h0001, 1, -1, bc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
